dmem_arbiter: RTL and testbench

- Shares the single-port data memory (8-bit word address, 32-bit data, synchronous read) between two requesters.
- Port 0 is the CPU load/store path; port 1 is a loader/debug DMA port.
- Arbitrates one access per cycle using round-robin with a bounded burst, or fixed priority.
- Drives the memory address, data and write-enable, then routes the read data back to the issuing port after the memory read latency.

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, synchronous-read data memory between
// two requesters. Port 0 is the CPU load/store path; port 1 is the loader/debug
// DMA port.
//
// The arbiter grants one access per cycle. Depending on FIXED_PRIO it uses
// either round-robin with a bounded burst or a fixed priority that favours
// port 0. Read data is steered back to the issuing port RD_LAT cycles later.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   pN_req/we/addr/wdata request from port N (held stable until pN_gnt)
//   pN_gnt              request accepted this cycle (combinational)
//   pN_rvalid/rdata     read return for port N (rdata is mem_q, qualified by rvalid)
//   mem_addr/data/wren  memory drive (zero when nothing is granted)
//   mem_q               memory read data, valid RD_LAT cycles after the address
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t            state;
  logic [3:0]        beats;
  logic              ptr;      // port favoured from IDLE when both request
  logic              rd_issue;
  logic [RD_LAT-1:0] tag_v;    // read-return pipeline: valid bit per stage
  logic [RD_LAT-1:0] tag_p;    // read-return pipeline: issuing port per stage

  // Grants are forced low while reset is asserted so nothing reaches memory.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset) begin
      if (FIXED_PRIO != 0) begin
        p0_gnt = p0_req;
        p1_gnt = p1_req && !p0_req;
      end else begin
        case (state)
          IDLE: begin
            if (p0_req && p1_req) begin
              p0_gnt = !ptr;
              p1_gnt = ptr;
            end else begin
              p0_gnt = p0_req;
              p1_gnt = p1_req;
            end
          end
          OWN0: begin
            if (p0_req && (!p1_req || beats < BMAX)) p0_gnt = 1'b1;
            else                                     p1_gnt = p1_req;
          end
          OWN1: begin
            if (p1_req && (!p0_req || beats < BMAX)) p1_gnt = 1'b1;
            else                                     p0_gnt = p0_req;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beats <= '0;
      ptr   <= 1'b0;
    end else if (p0_gnt) begin
      if (state != OWN0)   beats <= 4'd1;
      else if (beats < BMAX) beats <= beats + 4'd1;
      state <= OWN0;
    end else if (p1_gnt) begin
      if (state != OWN1)   beats <= 4'd1;
      else if (beats < BMAX) beats <= beats + 4'd1;
      state <= OWN1;
    end else begin
      // Leaving ownership idle: next contested IDLE grant goes to the other port.
      if (state == OWN0)      ptr <= 1'b1;
      else if (state == OWN1) ptr <= 1'b0;
      state <= IDLE;
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (p0_gnt) begin
      mem_addr = p0_addr;
      mem_data = p0_wdata;
      mem_wren = p0_we;
    end else if (p1_gnt) begin
      mem_addr = p1_addr;
      mem_data = p1_wdata;
      mem_wren = p1_we;
    end
  end

  assign rd_issue = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        tag_v <= '0;
        tag_p <= '0;
      end else begin
        tag_v <= rd_issue;
        tag_p <= p1_gnt;
      end
    end
  end else begin : g_latn
    always_ff @(posedge clk) begin
      if (reset) begin
        tag_v <= '0;
        tag_p <= '0;
      end else begin
        tag_v <= {tag_v[RD_LAT-2:0], rd_issue};
        tag_p <= {tag_p[RD_LAT-2:0], p1_gnt};
      end
    end
  end

  assign p0_rvalid = tag_v[RD_LAT-1] && !tag_p[RD_LAT-1];
  assign p1_rvalid = tag_v[RD_LAT-1] &&  tag_p[RD_LAT-1];
  assign p0_rdata  = mem_q;
  assign p1_rdata  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Three instances share the request inputs:
//   A: round-robin, RD_LAT=1;  B: fixed priority, RD_LAT=1;  C: round-robin, RD_LAT=2.
// Each instance has its own synchronous-read memory model backed by a ROM function.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;

  logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid, a_mem_wren;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_data, qa;
  logic [7:0]  a_mem_addr;
  logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid, b_mem_wren;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_data, qb;
  logic [7:0]  b_mem_addr;
  logic        c_p0_gnt, c_p0_rvalid, c_p1_gnt, c_p1_rvalid, c_mem_wren;
  logic [31:0] c_p0_rdata, c_p1_rdata, c_mem_data, qc1, qc2;
  logic [7:0]  c_mem_addr;

  int vec_cnt = 0;
  int err_cnt = 0;

  dmem_arbiter #(.RD_LAT(1), .BURST_MAX(4), .FIXED_PRIO(0)) u_a (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
    .mem_addr(a_mem_addr), .mem_data(a_mem_data), .mem_wren(a_mem_wren), .mem_q(qa)
  );

  dmem_arbiter #(.RD_LAT(1), .BURST_MAX(4), .FIXED_PRIO(1)) u_b (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_wren(b_mem_wren), .mem_q(qb)
  );

  dmem_arbiter #(.RD_LAT(2), .BURST_MAX(4), .FIXED_PRIO(0)) u_c (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(c_p0_gnt), .p0_rvalid(c_p0_rvalid), .p0_rdata(c_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(c_p1_gnt), .p1_rvalid(c_p1_rvalid), .p1_rdata(c_p1_rdata),
    .mem_addr(c_mem_addr), .mem_data(c_mem_data), .mem_wren(c_mem_wren), .mem_q(qc2)
  );

  function automatic logic [31:0] rom(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5C35A, a};
  endfunction

  always @(posedge clk) begin
    qa  <= rom(a_mem_addr);
    qb  <= rom(b_mem_addr);
    qc1 <= rom(c_mem_addr);
    qc2 <= qc1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    step();
    step();
    reset  = 1'b0;
  endtask

  // Burst-yield schedule for instance A, one entry per cycle.
  localparam logic       P0R [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  localparam logic       P1R [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  localparam logic [7:0] P1A [8] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h44, 8'h45, 8'h45};
  localparam logic [1:0] EGN [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00};
  localparam logic [7:0] EMA [8] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h44, 8'h45, 8'h00};
  localparam logic [1:0] ERV [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
  localparam logic [7:0] ERA [8] = '{8'h00, 8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h44, 8'h45};

  initial begin
    reset = 1'b1;
    p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = 8'h00; p1_addr = 8'h01; p0_wdata = '0; p1_wdata = '0;

    // Reset with both requesting: nothing granted, nothing written or returned.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt", {a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt, c_p0_gnt, c_p1_gnt}, 0);
      chk("rst_wren", {a_mem_wren, b_mem_wren, c_mem_wren}, 0);
      chk("rst_rvalid", {a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid,
                         c_p0_rvalid, c_p1_rvalid}, 0);
      step();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_gnt_a", {a_p0_gnt, a_p1_gnt}, 2'b10);
    chk("first_gnt_c", {c_p0_gnt, c_p1_gnt}, 2'b10);
    step();

    // Single read, RD_LAT=1.
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
    @(negedge clk);
    chk("rd_gnt", {a_p0_gnt, a_p1_gnt}, 2'b10);
    chk("rd_addr", a_mem_addr, 8'h10);
    chk("rd_wren", a_mem_wren, 1'b0);
    step();
    p0_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", {a_p0_rvalid, a_p1_rvalid}, 2'b10);
    chk("rd_rdata", a_p0_rdata, 32'hDEADBEEF);
    step();

    // Both ports stream writes: A alternates in bursts of 4, B always picks port 0.
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h20; p0_wdata = 32'h11111111;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h30; p1_wdata = 32'h22222222;
    for (int i = 0; i < 12; i++) begin
      int e;
      e = (i / 4) % 2;
      @(negedge clk);
      chk("rr_gnt", {a_p0_gnt, a_p1_gnt, a_mem_wren}, (e != 0) ? 3'b011 : 3'b101);
      chk("rr_data", a_mem_data, (e != 0) ? 32'h22222222 : 32'h11111111);
      chk("rr_addr", a_mem_addr, (e != 0) ? 8'h30 : 8'h20);
      if (i < 10) chk("fp_gnt", {b_p0_gnt, b_p1_gnt}, 2'b10);
      step();
    end
    p0_req = 1'b0;
    @(negedge clk);
    chk("fp_yield", {b_p0_gnt, b_p1_gnt}, 2'b01);
    step();
    p1_req = 1'b0;

    // Burst yield: p1 streams reads, p0 joins at p1 beat 2 and wins after beat 4.
    do_reset();
    p0_we = 1'b0; p1_we = 1'b0; p0_addr = 8'h50;
    for (int k = 0; k < 8; k++) begin
      p0_req  = P0R[k];
      p1_req  = P1R[k];
      p1_addr = P1A[k];
      @(negedge clk);
      chk("by_gnt", {a_p0_gnt, a_p1_gnt}, EGN[k]);
      chk("by_addr", a_mem_addr, EMA[k]);
      chk("by_rvalid", {a_p0_rvalid, a_p1_rvalid}, ERV[k]);
      if (ERV[k] == 2'b10) chk("by_rdata0", a_p0_rdata, rom(ERA[k]));
      if (ERV[k] == 2'b01) chk("by_rdata1", a_p1_rdata, rom(ERA[k]));
      step();
    end
    p0_req = 1'b0; p1_req = 1'b0;

    // RD_LAT=2 read returns two cycles after grant.
    do_reset();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h61;
    @(negedge clk);
    chk("l2_gnt", c_p1_gnt, 1'b1);
    step();
    p1_req = 1'b0;
    @(negedge clk);
    chk("l2_rv_early", {c_p0_rvalid, c_p1_rvalid}, 2'b00);
    step();
    @(negedge clk);
    chk("l2_rv", {c_p0_rvalid, c_p1_rvalid}, 2'b01);
    chk("l2_rdata", c_p1_rdata, rom(8'h61));
    step();

    // Reset while a read is in flight discards it; arbiter restarts from IDLE.
    p1_req = 1'b1; p1_addr = 8'h60;
    @(negedge clk);
    chk("fl_gnt", c_p1_gnt, 1'b1);
    step();
    reset = 1'b1; p1_req = 1'b0;
    @(negedge clk);
    chk("fl_rst", {c_p1_gnt, c_p1_rvalid}, 2'b00);
    step();
    reset = 1'b0; p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
    @(negedge clk);
    chk("fl_rv_t2", c_p1_rvalid, 1'b0);
    chk("fl_idle", {c_p0_gnt, c_p1_gnt}, 2'b10);
    step();
    p0_req = 1'b0; p1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_rv_late", c_p1_rvalid, 1'b0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
